// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RISC-V style control FSM with INPUT/OUTPUT instructions, retire counter
// and an optional illegal-opcode trap state (enabled by defining MC_CTRL_TRAP_EN).
module mc_control_fsm #(
    parameter logic [6:0] OP_INPUT  = 7'b0001011,
    parameter logic [6:0] OP_OUTPUT = 7'b0101011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic        InputSRC,
    output logic        OutputSRC,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  state,
    output logic [15:0] instret,
    output logic        trap
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_INPUT    = 4'd10,
        S_OUTPUT   = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t cur, nxt, tgt;
    logic pcw_r, inc;
    logic n_pcw, n_irw, n_mw, n_rw, n_adr, n_in, n_out;
    logic [1:0] n_rs, n_sa, n_sb, n_imm;
    logic [2:0] n_alu, alu_op;

    // Next-state logic; reset forces the target state to FETCH so outputs follow it on the same edge
    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (op == OP_LOAD || op == OP_STORE) nxt = S_MEMADR;
                else if (op == OP_RTYPE) nxt = S_EXECUTER;
                else if (op == OP_ITYPE) nxt = S_EXECUTEI;
                else if (op == OP_BEQ) nxt = S_BEQ;
                else if (op == OP_INPUT) nxt = S_INPUT;
                else if (op == OP_OUTPUT) nxt = S_OUTPUT;
`ifdef MC_CTRL_TRAP_EN
                else nxt = S_TRAP;
`else
                else nxt = S_FETCH;
`endif
            end
            S_MEMADR:   nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt = S_MEMWB;
            S_EXECUTER: nxt = S_ALUWB;
            S_EXECUTEI: nxt = S_ALUWB;
`ifdef MC_CTRL_TRAP_EN
            S_TRAP:     nxt = S_TRAP;
`endif
            default:    nxt = S_FETCH;
        endcase
        tgt = rst ? S_FETCH : nxt;
        inc = (nxt == S_FETCH) && (cur != S_FETCH) && (cur != S_TRAP);
        alu_op = (funct3 == 3'b000) ? ((tgt == S_EXECUTER && funct7_5) ? 3'b001 : 3'b000) :
                 (funct3 == 3'b010) ? 3'b101 :
                 (funct3 == 3'b110) ? 3'b011 :
                 (funct3 == 3'b111) ? 3'b010 : 3'b000;
    end

    // Output decode of the state being entered, so registered outputs line up with the state register
    always_comb begin
        n_pcw = 1'b0;
        n_irw = 1'b0;
        n_mw  = 1'b0;
        n_rw  = 1'b0;
        n_adr = 1'b0;
        n_in  = 1'b0;
        n_out = 1'b0;
        n_rs  = 2'b00;
        n_sa  = 2'b00;
        n_sb  = 2'b00;
        n_imm = 2'b00;
        n_alu = 3'b000;
        case (tgt)
            S_FETCH: begin
                n_irw = 1'b1;
                n_pcw = 1'b1;
                n_sb  = 2'b10;
                n_rs  = 2'b10;
            end
            S_DECODE: begin
                n_sa  = 2'b01;
                n_sb  = 2'b01;
                n_imm = 2'b10;
            end
            S_MEMADR: begin
                n_sa  = 2'b10;
                n_sb  = 2'b01;
                n_imm = (op == OP_LOAD) ? 2'b00 : 2'b01;
            end
            S_MEMREAD:  n_adr = 1'b1;
            S_MEMWB: begin
                n_rs = 2'b01;
                n_rw = 1'b1;
            end
            S_MEMWRITE: begin
                n_adr = 1'b1;
                n_mw  = 1'b1;
            end
            S_EXECUTER: begin
                n_sa  = 2'b10;
                n_alu = alu_op;
            end
            S_EXECUTEI: begin
                n_sa  = 2'b10;
                n_sb  = 2'b01;
                n_alu = alu_op;
            end
            S_ALUWB:    n_rw = 1'b1;
            S_BEQ: begin
                n_sa  = 2'b10;
                n_alu = 3'b001;
            end
            S_INPUT: begin
                n_in = 1'b1;
                n_rw = 1'b1;
            end
            S_OUTPUT:   n_out = 1'b1;
            default:    n_pcw = 1'b0;
        endcase
    end

    // State register, registered outputs and retired-instruction counter
    always_ff @(posedge clk) begin
        cur        <= tgt;
        pcw_r      <= n_pcw;
        IRWrite    <= n_irw;
        MemWrite   <= n_mw;
        RegWrite   <= n_rw;
        AdrSrc     <= n_adr;
        InputSRC   <= n_in;
        OutputSRC  <= n_out;
        ResultSrc  <= n_rs;
        ALUSrcA    <= n_sa;
        ALUSrcB    <= n_sb;
        ImmSrc     <= n_imm;
        ALUControl <= n_alu;
        if (rst) instret <= 16'd0;
        else if (inc) instret <= instret + 16'd1;
    end

`ifdef MC_CTRL_TRAP_EN
    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk) begin
        trap <= rst ? 1'b0 : (trap | (tgt == S_TRAP));
    end
`else
    assign trap = 1'b0;
`endif

    // Branch PC update is taken straight from the ALU zero flag while in BEQ
    assign PCWrite = pcw_r | ((cur == S_BEQ) & Zero);
    assign state   = cur;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench; stimulus pushes expected per-cycle state/outputs, a monitor pops and compares.
module tb_mc_control_fsm;
    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic funct7_5 = 1'b0, Zero = 1'b0;
    logic PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, InputSRC, OutputSRC;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic [15:0] instret;
    logic trap;

    int checks = 0, failures = 0;
    logic [15:0] eir = 16'd0;
    logic etr = 1'b0;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [15:0] ir;
        logic        tr;
        string       tag;
    } exp_t;
    exp_t q[$];

    // ctl = {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,InputSRC,OutputSRC,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
    localparam logic [17:0] C_FETCH  = {7'b1100000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [17:0] C_DEC    = {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000};
    localparam logic [17:0] C_MADR_L = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000};
    localparam logic [17:0] C_MADR_S = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000};
    localparam logic [17:0] C_MREAD  = {7'b0000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] C_MWB    = {7'b0001000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] C_MWR    = {7'b0010100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] C_ALUWB  = {7'b0001000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] C_IN     = {7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] C_OUT    = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] C_NONE   = 18'd0;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .InputSRC(InputSRC), .OutputSRC(OutputSRC), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .state(state), .instret(instret), .trap(trap)
    );

    always #5 clk = ~clk;

    // Monitor: after each rising edge, compare the DUT against the oldest pending expectation
    initial begin
        exp_t e;
        logic [17:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, InputSRC, OutputSRC,
                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
                checks++;
                if (state !== e.st || act !== e.ctl || instret !== e.ir || trap !== e.tr) begin
                    failures++;
                    $display("FAIL %s: got state=%0d ctl=%b instret=%h trap=%b, want state=%0d ctl=%b instret=%h trap=%b",
                             e.tag, state, act, instret, trap, e.st, e.ctl, e.ir, e.tr);
                end
            end
        end
    end

    // Expectation for the cycle after the next rising edge; inputs are already driven for that edge
    task automatic exp_cyc(input logic [3:0] st, input logic [17:0] ctl, input string tag);
        exp_t e;
        e.st = st;
        e.ctl = ctl;
        e.ir = eir;
        e.tr = etr;
        e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic retire(input string tag);
        eir = eir + 16'd1;
        exp_cyc(4'd0, C_FETCH, tag);
    endtask

    task automatic do_load();
        op = 7'b0000011;
        exp_cyc(4'd1, C_DEC, "ld_decode");
        exp_cyc(4'd2, C_MADR_L, "ld_memadr");
        exp_cyc(4'd3, C_MREAD, "ld_memread");
        exp_cyc(4'd4, C_MWB, "ld_memwb");
        retire("ld_fetch");
    endtask

    task automatic do_store();
        op = 7'b0100011;
        exp_cyc(4'd1, C_DEC, "st_decode");
        exp_cyc(4'd2, C_MADR_S, "st_memadr");
        exp_cyc(4'd5, C_MWR, "st_memwrite");
        retire("st_fetch");
    endtask

    task automatic do_alu(input logic imm, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
        op = imm ? 7'b0010011 : 7'b0110011;
        funct3 = f3;
        funct7_5 = f7;
        exp_cyc(4'd1, C_DEC, "alu_decode");
        if (imm) exp_cyc(4'd7, {7'b0, 2'b00, 2'b10, 2'b01, 2'b00, alu}, "executei");
        else exp_cyc(4'd6, {7'b0, 2'b00, 2'b10, 2'b00, 2'b00, alu}, "executer");
        exp_cyc(4'd8, C_ALUWB, "aluwb");
        retire("alu_fetch");
    endtask

    task automatic do_beq(input logic z);
        op = 7'b1100011;
        Zero = z;
        exp_cyc(4'd1, C_DEC, "beq_decode");
        exp_cyc(4'd9, {z, 6'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001}, "beq");
        retire("beq_fetch");
        Zero = 1'b0;
    endtask

    task automatic do_io(input logic is_in);
        op = is_in ? 7'b0001011 : 7'b0101011;
        exp_cyc(4'd1, C_DEC, "io_decode");
        if (is_in) exp_cyc(4'd10, C_IN, "input");
        else exp_cyc(4'd11, C_OUT, "output");
        retire("io_fetch");
    endtask

    // Stimulus
    initial begin
        @(negedge clk);
        exp_cyc(4'd0, C_FETCH, "reset1");
        exp_cyc(4'd0, C_FETCH, "reset2");
        rst = 1'b0;
        do_load();
        do_store();
        do_alu(1'b0, 3'b000, 1'b1, 3'b001);
        do_alu(1'b0, 3'b000, 1'b0, 3'b000);
        do_alu(1'b1, 3'b000, 1'b1, 3'b000);
        do_alu(1'b0, 3'b010, 1'b0, 3'b101);
        do_alu(1'b1, 3'b110, 1'b0, 3'b011);
        do_alu(1'b0, 3'b111, 1'b1, 3'b010);
        do_alu(1'b1, 3'b100, 1'b0, 3'b000);
        do_beq(1'b1);
        do_beq(1'b0);
        do_io(1'b1);
        do_io(1'b0);
        op = 7'b1111111;
        exp_cyc(4'd1, C_DEC, "ill_decode");
`ifdef MC_CTRL_TRAP_EN
        etr = 1'b1;
        exp_cyc(4'd12, C_NONE, "trap1");
        exp_cyc(4'd12, C_NONE, "trap2");
        exp_cyc(4'd12, C_NONE, "trap3");
        rst = 1'b1;
        eir = 16'd0;
        etr = 1'b0;
        exp_cyc(4'd0, C_FETCH, "trap_reset");
        rst = 1'b0;
`else
        retire("ill_nop");
`endif
        op = 7'b0000011;
        exp_cyc(4'd1, C_DEC, "mid_decode");
        exp_cyc(4'd2, C_MADR_L, "mid_memadr");
        rst = 1'b1;
        eir = 16'd0;
        exp_cyc(4'd0, C_FETCH, "mid_reset");
        rst = 1'b0;
        do_io(1'b1);
        // Jump the counter to its last value instead of retiring 65535 instructions
        force dut.instret = 16'hFFFF;
        release dut.instret;
        eir = 16'hFFFF;
        do_io(1'b0);
        do_load();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
